// File: rtl/pc_sequencer_if.sv
// Bundle of the PC sequencer's adder, redirect and fetch handshake signals.
// The master side is the sequencer; the slave side is the adder plus fetch/pipeline.
interface pc_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic             stall;
  logic             redirect_valid;
  logic [WIDTH-1:0] redirect_target;
  logic             fetch_valid;
  logic             fetch_ready;
  logic [WIDTH-1:0] pc;
  logic [31:0]      fetch_count;
  logic             halted;
  logic [1:0]       fault;

  modport master (
    output add_a, add_b, add_cin, fetch_valid, pc, fetch_count, halted, fault,
    input  add_sum, add_cout, stall, redirect_valid, redirect_target, fetch_ready
  );

  modport slave (
    input  add_a, add_b, add_cin, fetch_valid, pc, fetch_count, halted, fault,
    output add_sum, add_cout, stall, redirect_valid, redirect_target, fetch_ready
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: offers PCs to fetch, advances via the external adder,
// takes redirects, and halts permanently (until reset) on misaligned targets or PC wrap.
module pc_sequencer #(
  parameter int unsigned     WIDTH        = 32,
  parameter int unsigned     STEP         = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic           clk,
  input  logic           rst_n,
  pc_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT
  } state_t;

  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STEP - 1);

  state_t           state, stateNext;
  logic [WIDTH-1:0] pcReg, pcNext;
  logic [31:0]      countReg, countNext;
  logic [1:0]       faultReg, faultNext;
  logic             fetchValid;
  logic             accept;
  logic             targetAligned;

  assign fetchValid    = (state == RUN) && !bus.stall;
  assign accept        = fetchValid && bus.fetch_ready;
  assign targetAligned = (bus.redirect_target & ALIGN_MASK) == '0;

  assign bus.add_a       = pcReg;
  assign bus.add_b       = WIDTH'(STEP);
  assign bus.add_cin     = 1'b0;
  assign bus.fetch_valid = fetchValid;
  assign bus.pc          = pcReg;
  assign bus.fetch_count = countReg;
  assign bus.halted      = (state == HALT);
  assign bus.fault       = faultReg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= BOOT;
      pcReg    <= RESET_VECTOR;
      countReg <= '0;
      faultReg <= 2'b00;
    end else begin
      state    <= stateNext;
      pcReg    <= pcNext;
      countReg <= countNext;
      faultReg <= faultNext;
    end
  end

  // Redirects outrank everything, so an aligned one lands even under stall or backpressure;
  // the accept is still counted when a redirect or fault shares its cycle.
  always_comb begin
    stateNext = state;
    pcNext    = pcReg;
    countNext = countReg;
    faultNext = faultReg;
    unique case (state)
      BOOT: stateNext = RUN;
      RUN: begin
        if (accept) countNext = countReg + 32'd1;
        if (bus.redirect_valid && targetAligned) begin
          pcNext = bus.redirect_target;
        end else if (bus.redirect_valid) begin
          stateNext = HALT;
          faultNext = 2'b01;
        end else if (accept && bus.add_cout) begin
          stateNext = HALT;
          faultNext = 2'b10;
        end else if (accept) begin
          pcNext = bus.add_sum;
        end
      end
      HALT: stateNext = HALT;
      default: stateNext = BOOT;
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a scoreboard of expected accepted PCs per instance
// plus status checks on count, fault, halt and reset behaviour.
module tb_pc_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  logic rstW_n;

  int checkCount = 0;
  int passCount  = 0;

  logic [31:0] expQ[$];
  logic [31:0] expWQ[$];

  always #5 clk = ~clk;

  pc_sequencer_if #(.WIDTH(32)) bus ();
  pc_sequencer_if #(.WIDTH(32)) busW ();

  pc_sequencer #(.WIDTH(32), .STEP(4), .RESET_VECTOR(32'h0000_0000)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  pc_sequencer #(.WIDTH(32), .STEP(4), .RESET_VECTOR(32'hFFFF_FFF8)) dutWrap (
    .clk  (clk),
    .rst_n(rstW_n),
    .bus  (busW)
  );

  // Behavioural stand-in for the downstream adder.
  assign {bus.add_cout, bus.add_sum}   = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {32'd0, bus.add_cin};
  assign {busW.add_cout, busW.add_sum} = {1'b0, busW.add_a} + {1'b0, busW.add_b} + {32'd0, busW.add_cin};

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic ready, input logic stl, input logic rv, input logic [31:0] tgt);
    bus.fetch_ready     = ready;
    bus.stall           = stl;
    bus.redirect_valid  = rv;
    bus.redirect_target = tgt;
  endtask

  task automatic stepTo();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitors: every accepted fetch must match the next queued PC.
  always @(negedge clk) begin
    if (bus.fetch_valid && bus.fetch_ready) begin
      if (expQ.size() == 0) checkOutput("unexpected accept", bus.pc, 32'hDEAD_BEEF);
      else checkOutput("accepted pc", bus.pc, expQ.pop_front());
    end
  end

  always @(negedge clk) begin
    if (busW.fetch_valid && busW.fetch_ready) begin
      if (expWQ.size() == 0) checkOutput("unexpected wrap accept", busW.pc, 32'hDEAD_BEEF);
      else checkOutput("wrap accepted pc", busW.pc, expWQ.pop_front());
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n  = 1'b0;
    rstW_n = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    busW.fetch_ready     = 1'b1;
    busW.stall           = 1'b0;
    busW.redirect_valid  = 1'b0;
    busW.redirect_target = 32'h0;

    repeat (2) stepTo();
    checkOutput("reset pc", bus.pc, 32'h0);
    checkOutput("reset fetch_valid", {31'd0, bus.fetch_valid}, 32'd0);
    checkOutput("reset count", bus.fetch_count, 32'd0);
    checkOutput("reset halted", {31'd0, bus.halted}, 32'd0);
    checkOutput("reset fault", {30'd0, bus.fault}, 32'd0);

    rst_n = 1'b1;
    #1;
    checkOutput("boot fetch_valid", {31'd0, bus.fetch_valid}, 32'd0);
    expQ.push_back(32'h0);
    expQ.push_back(32'h4);
    expQ.push_back(32'h8);
    expQ.push_back(32'hC);
    stepTo();
    checkOutput("run fetch_valid", {31'd0, bus.fetch_valid}, 32'd1);
    repeat (4) stepTo();
    checkOutput("seq pc", bus.pc, 32'h10);
    checkOutput("seq count", bus.fetch_count, 32'd4);

    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (3) stepTo();
    checkOutput("backpressure pc", bus.pc, 32'h10);
    checkOutput("backpressure count", bus.fetch_count, 32'd4);
    checkOutput("backpressure valid", {31'd0, bus.fetch_valid}, 32'd1);

    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    #1;
    checkOutput("stall valid", {31'd0, bus.fetch_valid}, 32'd0);
    stepTo();
    checkOutput("stall pc", bus.pc, 32'h10);
    checkOutput("stall count", bus.fetch_count, 32'd4);

    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    expQ.push_back(32'h10);
    stepTo();
    checkOutput("release pc", bus.pc, 32'h14);
    checkOutput("release count", bus.fetch_count, 32'd5);

    applyStimulus(1'b0, 1'b1, 1'b1, 32'h100);
    stepTo();
    checkOutput("stalled redirect pc", bus.pc, 32'h100);
    checkOutput("stalled redirect count", bus.fetch_count, 32'd5);

    applyStimulus(1'b1, 1'b0, 1'b1, 32'h200);
    expQ.push_back(32'h100);
    stepTo();
    checkOutput("redirect+accept pc", bus.pc, 32'h200);
    checkOutput("redirect+accept count", bus.fetch_count, 32'd6);

    applyStimulus(1'b0, 1'b0, 1'b1, 32'h102);
    stepTo();
    checkOutput("misaligned halted", {31'd0, bus.halted}, 32'd1);
    checkOutput("misaligned fault", {30'd0, bus.fault}, 32'd1);
    checkOutput("misaligned pc", bus.pc, 32'h200);
    checkOutput("misaligned valid", {31'd0, bus.fetch_valid}, 32'd0);
    checkOutput("misaligned count", bus.fetch_count, 32'd6);

    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0);
    stepTo();
    checkOutput("halt ignores redirect pc", bus.pc, 32'h200);
    checkOutput("halt keeps fault", {30'd0, bus.fault}, 32'd1);
    checkOutput("halt keeps halted", {31'd0, bus.halted}, 32'd1);
    checkOutput("halt keeps count", bus.fetch_count, 32'd6);

    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async reset pc", bus.pc, 32'h0);
    checkOutput("async reset fault", {30'd0, bus.fault}, 32'd0);
    checkOutput("async reset halted", {31'd0, bus.halted}, 32'd0);
    checkOutput("async reset valid", {31'd0, bus.fetch_valid}, 32'd0);
    checkOutput("async reset count", bus.fetch_count, 32'd0);
    #1 rst_n = 1'b1;
    expQ.push_back(32'h0);
    expQ.push_back(32'h4);
    stepTo();
    checkOutput("reboot valid", {31'd0, bus.fetch_valid}, 32'd1);
    repeat (2) stepTo();
    checkOutput("reboot pc", bus.pc, 32'h8);
    checkOutput("reboot count", bus.fetch_count, 32'd2);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);

    rstW_n = 1'b1;
    expWQ.push_back(32'hFFFF_FFF8);
    expWQ.push_back(32'hFFFF_FFFC);
    repeat (3) stepTo();
    checkOutput("wrap fault", {30'd0, busW.fault}, 32'd2);
    checkOutput("wrap halted", {31'd0, busW.halted}, 32'd1);
    checkOutput("wrap pc", busW.pc, 32'hFFFF_FFFC);
    checkOutput("wrap count", busW.fetch_count, 32'd2);
    checkOutput("wrap valid", {31'd0, busW.fetch_valid}, 32'd0);
    stepTo();
    checkOutput("wrap frozen pc", busW.pc, 32'hFFFF_FFFC);
    checkOutput("wrap frozen count", busW.fetch_count, 32'd2);

    stepTo();
    checkOutput("scoreboard drained", expQ.size(), 32'd0);
    checkOutput("wrap scoreboard drained", expWQ.size(), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
